nios2cpu_mult_seq: RTL
======================

# nios2cpu_mult_seq

Parametrised, iterative integer multiplier for the Nios II CPU datapath. It reuses a single SLICE_W x SLICE_W unsigned hardware multiplier over several cycles to form the full 2*DATA_W product. It adds signed/unsigned and high/low-word modes (mul, mulxuu, mulxsu, mulxss) and a valid/ready handshake on both sides. It sits between the A-stage operand registers and the writeback mux, serving both cores with 16-bit DSP blocks and wider-datapath variants.

## Interface
- DATA_W, 32, operand and result width; must be an integer multiple of SLICE_W (elaboration error otherwise)
- SLICE_W, 16, width of the hardware multiplier slice; N = DATA_W/SLICE_W
- clk  input  1  clock, all state updates on rising edge
- reset_n  input  1  reset, synchronous and active-low
- in_valid  input  1  operands/op presented
- in_ready  output  1  block can accept; 1 only in IDLE
- in_src1  input  DATA_W  operand A
- in_src2  input  DATA_W  operand B
- in_op  input  2  00 MUL (low word), 01 MULXUU (high, A/B unsigned), 10 MULXSU (high, A signed, B unsigned), 11 MULXSS (high, both signed)
- out_valid  output  1  result held valid
- out_ready  input  1  consumer takes result
- out_result  output  DATA_W  selected result word

## Operation
- FSM states: IDLE, MUL, CORR, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch src1, src2 and op; clear the 2*DATA_W accumulator; clear step counter k; go to MUL. Inputs may change freely after acceptance.
- MUL: one partial product per cycle for k = 0..N*N-1, with i = k mod N (A slice) and j = k div N (B slice).
  - acc <= acc + (A[i] * B[j]) << (SLICE_W*(i+j)), modulo 2^(2*DATA_W).
  - Slices are unsigned.
  - After k = N*N-1, go to CORR.
  - Step count is fixed and independent of op and operand values.
- CORR: signed correction of the high word, arithmetic modulo 2^DATA_W.
  - hi = acc_hi - (signA ? B : 0) - (signB ? A : 0).
  - signA = A[DATA_W-1] for MULXSU and MULXSS, else 0.
  - signB = B[DATA_W-1] for MULXSS only.
  - The low word never needs correction.
  - Register out_result = acc_lo for MUL, else the corrected hi. Go to DONE.
- DONE: out_valid=1; out_result is held stable.
  - On out_ready, go to IDLE.
  - in_ready=0 throughout DONE; a new op cannot be accepted in the same cycle the result is taken.
- in_valid outside IDLE is ignored and not queued.

## Timing
- Reset (reset_n sampled low on an edge): state=IDLE, out_valid=0, out_result=0, accumulator=0, k=0, latched operands=0.
- in_ready=1 from the first cycle after reset_n is sampled high. Reset asserted in any state aborts the operation with no output.
- Latency: acceptance edge E0, then N*N MUL edges, then 1 CORR edge. out_valid is high after edge E0+N*N+1 (5 cycles for default parameters, 17 for DATA_W=64/SLICE_W=16).
- Initiation interval: N*N+3 cycles minimum (IDLE, MUL x N*N, CORR, DONE) with out_ready held high.
- out_ready has no effect outside DONE. With out_ready low, DONE persists indefinitely with out_result unchanged.
- out_result changes only on the CORR->DONE edge and on reset.
- The critical path is one SLICE_W x SLICE_W multiply plus a 2*DATA_W add. The slice product is not registered.

## Test plan
- MUL 0x0001_2345 * 0x0000_1000, out_ready=1 -> out_result 0x1234_5000. out_valid rises exactly 5 cycles after the accept edge and is high for 1 cycle.
- 0xFFFF_FFFF * 0xFFFF_FFFF under each op -> MUL 0x0000_0001, MULXUU 0xFFFF_FFFE, MULXSU 0xFFFF_FFFF, MULXSS 0x0000_0000.
- MULXSS 0x8000_0000 * 0x8000_0000 -> 0x4000_0000. MULXSU 0x8000_0000 * 0x0000_0002 -> 0xFFFF_FFFF.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, pulse in_valid with new operands during that time, and change in_src1/in_src2 -> out_result stable, in_ready=0, new request not accepted. Release out_ready -> one cycle later in_ready=1 and the next op computes correctly.
- Reset mid-op: assert reset_n=0 for one edge during MUL step k=2 -> next cycle out_valid=0, out_result=0, in_ready=1. A following MUL 3*7 returns 0x0000_0015.
- DATA_W=64, SLICE_W=16: MULXUU all-ones * all-ones -> 0xFFFF_FFFF_FFFF_FFFE after 17 cycles. MUL 0x1_0000_0000 * 0x1_0000_0000 -> 0.

Source files
------------

// File: rtl/nios2cpu_mult_seq.sv
// nios2cpu_mult_seq: iterative signed/unsigned multiplier reusing one SLICE_W x SLICE_W slice
module nios2cpu_mult_seq #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [1:0]        in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result
);
  localparam int N     = DATA_W / SLICE_W;
  localparam int STEPS = N * N;
  localparam int KW    = STEPS > 1 ? $clog2(STEPS) : 1;
  localparam int PW    = 2 * DATA_W;
  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_XSU = 2'b10;
  localparam logic [1:0] OP_XSS = 2'b11;

  if (DATA_W % SLICE_W != 0 || DATA_W < SLICE_W) begin : g_width_check
    $error("DATA_W must be a positive multiple of SLICE_W");
  end

  typedef enum logic [1:0] {IDLE, MUL, CORR, DONE} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] a, b;
  logic [1:0]        op;
  logic [PW-1:0]     acc, pp;
  logic [KW-1:0]     k;
  logic [SLICE_W-1:0] a_sl, b_sl;
  logic [DATA_W-1:0] hi;
  logic              sign_a, sign_b, last;
  int                i, j;

  // partial product of the current slice pair, aligned to its weight, plus high-word sign correction
  always_comb begin
    i      = int'(k) % N;
    j      = int'(k) / N;
    a_sl   = SLICE_W'(a >> (SLICE_W * i));
    b_sl   = SLICE_W'(b >> (SLICE_W * j));
    pp     = (PW'(a_sl) * PW'(b_sl)) << (SLICE_W * (i + j));
    last   = k == KW'(STEPS - 1);
    sign_a = (op == OP_XSU || op == OP_XSS) && a[DATA_W-1];
    sign_b = op == OP_XSS && b[DATA_W-1];
    hi     = acc[PW-1:DATA_W] - (sign_a ? b : '0) - (sign_b ? a : '0);
  end

  // next-state and handshake outputs
  always_comb begin
    state_nx  = state;
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    case (state)
      IDLE: state_nx = in_valid ? MUL : IDLE;
      MUL:  state_nx = last ? CORR : MUL;
      CORR: state_nx = DONE;
      DONE: state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  end

  // operand latch, accumulation, and result capture on the CORR->DONE edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a          <= '0;
      b          <= '0;
      op         <= '0;
      acc        <= '0;
      k          <= '0;
      out_result <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        a   <= in_src1;
        b   <= in_src2;
        op  <= in_op;
        acc <= '0;
        k   <= '0;
      end
      if (state == MUL) begin
        acc <= acc + pp;
        k   <= last ? '0 : k + 1'b1;
      end
      if (state == CORR) out_result <= op == OP_MUL ? acc[DATA_W-1:0] : hi;
    end
  end
endmodule
